// File: rtl/graystep_seq_ctrl.sv
// Command-driven sequencer for a 2-bit Gray-coded phase counter with signed position tracking.
// Optional soft-start ramp on the first three steps of a move when GRAYSTEP_RAMP_EN is defined.
module graystep_seq_ctrl #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 12,
  parameter int POS_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic [1:0]       phase,
  output logic             step_pulse,
  output logic             busy,
  output logic             done,
  output logic             done_aborted,
  output logic [POS_W-1:0] position
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dab_q, dab_d;
  logic             aborted_q, aborted_d;
`ifdef GRAYSTEP_RAMP_EN
  // ramp_q: extra reloads owed by the next interval; rep_q: reloads left in the current one
  logic [1:0]       ramp_q, ramp_d;
  logic [1:0]       rep_q, rep_d;
`endif

  function automatic logic [1:0] gray_step(input logic [1:0] p, input logic rev);
    logic [1:0] n;
    case ({rev, p})
      3'b0_00: n = 2'b01;
      3'b0_01: n = 2'b11;
      3'b0_11: n = 2'b10;
      3'b0_10: n = 2'b00;
      3'b1_00: n = 2'b10;
      3'b1_10: n = 2'b11;
      3'b1_11: n = 2'b01;
      3'b1_01: n = 2'b00;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      steps_q   <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      phase_q   <= 2'b00;
      pos_q     <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dab_q     <= 1'b0;
      aborted_q <= 1'b0;
`ifdef GRAYSTEP_RAMP_EN
      ramp_q    <= '0;
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      steps_q   <= steps_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dab_q     <= dab_d;
      aborted_q <= aborted_d;
`ifdef GRAYSTEP_RAMP_EN
      ramp_q    <= ramp_d;
      rep_q     <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    steps_d   = steps_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    pos_d     = pos_q;
    pulse_d   = 1'b0;
    done_d    = 1'b0;
    dab_d     = 1'b0;
    aborted_d = aborted_q;
`ifdef GRAYSTEP_RAMP_EN
    ramp_d    = ramp_q;
    rep_d     = rep_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d     = cmd_dir;
          steps_d   = cmd_steps;
          period_d  = cmd_period;
          cnt_d     = cmd_period;
          aborted_d = 1'b0;
`ifdef GRAYSTEP_RAMP_EN
          ramp_d    = 2'd3;
          rep_d     = 2'd3;
`endif
          state_d   = (cmd_steps == '0) ? FIN : RUN;
        end
      end

      RUN: begin
        // abort takes priority over a step that is due this cycle
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
`ifdef GRAYSTEP_RAMP_EN
        end else if (rep_q != '0) begin
          rep_d = rep_q - 1'b1;
          cnt_d = period_q;
`endif
        end else begin
          phase_d = gray_step(phase_q, dir_q);
          pos_d   = dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
          pulse_d = 1'b1;
          steps_d = steps_q - 1'b1;
          cnt_d   = period_q;
`ifdef GRAYSTEP_RAMP_EN
          ramp_d  = (ramp_q == '0) ? 2'd0 : ramp_q - 1'b1;
          rep_d   = (ramp_q == '0) ? 2'd0 : ramp_q - 1'b1;
`endif
          if (steps_q == CNT_W'(1)) begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        done_d  = 1'b1;
        dab_d   = aborted_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  assign cmd_ready    = (state_q == IDLE);
  assign phase        = phase_q;
  assign step_pulse   = pulse_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign done_aborted = dab_q;
  assign position     = pos_q;

endmodule
